// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI master FSM states, {CPOL,CPHA} mode constants and frame-length helper.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_e;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int frame_cycles(input int data_w, input int clk_div);
        return (2 + 2 * data_w) * clk_div;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: CLK_DIV prescaler and registered SCLK with one-cycle leading/trailing edge strobes.
module spi_sclk_gen #(
    parameter int CLK_DIV = 2,
    parameter int CPOL    = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic toggle,
    output logic sclk,
    output logic tick,
    output logic lead,
    output logic trail
);

    localparam int            CW       = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST     = CW'(CLK_DIV - 1);
    localparam logic          IDLE_LVL = 1'(CPOL);

    logic [CW-1:0] cnt;

    // Strobes are high in the cycle before the clk edge on which sclk actually moves.
    assign tick  = en && cnt == LAST;
    assign lead  = tick && toggle && sclk == IDLE_LVL;
    assign trail = tick && toggle && sclk != IDLE_LVL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= IDLE_LVL;
        end else begin
            cnt <= (!en || tick) ? '0 : cnt + CW'(1);
            if (tick && toggle) sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: full-duplex SPI master, all CPOL/CPHA modes, programmable SCLK divider.
// Define SPI_MASTER_LOOPBACK_EN to add a loopback input that routes mosi into the receive path.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 2,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              miso
);

    localparam int            EW        = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    spi_state_e        state, state_nx;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic [EW-1:0]     edges;
    logic              tick, lead, trail, sample, shift, last, accept, rx_in;

    function automatic logic head(input logic [DATA_W-1:0] d);
        return MSB_FIRST != 0 ? d[DATA_W-1] : d[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] d);
        return MSB_FIRST != 0 ? d << 1 : d >> 1;
    endfunction

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV),
        .CPOL   (CPOL)
    ) u_sclk_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (state != IDLE),
        .toggle(state == XFER),
        .sclk  (sclk),
        .tick  (tick),
        .lead  (lead),
        .trail (trail)
    );

    assign tx_ready = state == IDLE;
    assign accept   = tx_valid && tx_ready;
    assign sample   = CPHA != 0 ? trail : lead;
    assign shift    = CPHA != 0 ? lead : trail;
    assign last     = edges == LAST_EDGE;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_in = loopback ? mosi : miso;
`else
    assign rx_in = miso;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? SETUP : IDLE;
            SETUP:   state_nx = tick ? XFER : SETUP;
            XFER:    state_nx = (tick && last) ? HOLD : XFER;
            HOLD:    state_nx = tick ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    // With CPHA=0 the first bit is already on mosi, so the trailing edge after the last bit must not shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            edges    <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (accept) begin
                cs_n  <= 1'b0;
                edges <= '0;
                mosi  <= CPHA != 0 ? 1'b0 : head(tx_data);
                tx_sh <= CPHA != 0 ? tx_data : advance(tx_data);
            end
            if (state == XFER) begin
                if (tick) edges <= edges + EW'(1);
                if (sample) rx_sh <= MSB_FIRST != 0 ? {rx_sh[DATA_W-2:0], rx_in} : {rx_in, rx_sh[DATA_W-1:1]};
                if (shift && !last) begin
                    mosi  <= head(tx_sh);
                    tx_sh <= advance(tx_sh);
                end
            end
            if (state == HOLD && tick) begin
                cs_n     <= 1'b1;
                mosi     <= 1'b0;
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: three masters in different modes/dividers driven against an edge-driven SPI slave model.
module tb_spi_master_param;

    localparam int DW        = 12;
    localparam int CPOL_A[3] = '{0, 1, 0};
    localparam int CPHA_A[3] = '{0, 1, 1};
    localparam int MSB_A[3]  = '{1, 1, 0};
    localparam int CD_A[3]   = '{2, 3, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] tx_valid = '0;
    logic [2:0] tx_ready, rx_valid, sclk, cs_n, mosi;
    logic [2:0] miso = '0;
    logic [2:0][DW-1:0] tx_data = '0;
    logic [2:0][DW-1:0] rx_data;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic [2:0] loopback = '0;
`endif

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    int nacc[3], nrx[3], nedge[3], nsamp[3], bidx[3], idle_bad[3], hi_run[3], gap[3];
    int acc_cyc[3], rx_cyc[3], fall_cyc[3], rise_cyc[3], last_lat[3], last_nedge[3];
    logic [DW-1:0] slv_word[3], got[3], last_rx[3], last_got[3];
    logic prev_sclk[3], prev_cs[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_master_param #(
            .DATA_W   (DW),
            .CLK_DIV  (CD_A[g]),
            .CPOL     (CPOL_A[g]),
            .CPHA     (CPHA_A[g]),
            .MSB_FIRST(MSB_A[g])
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .tx_data (tx_data[g]),
            .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]),
            .rx_data (rx_data[g]),
            .rx_valid(rx_valid[g]),
            .sclk    (sclk[g]),
            .cs_n    (cs_n[g]),
            .mosi    (mosi[g]),
`ifdef SPI_MASTER_LOOPBACK_EN
            .loopback(loopback[g]),
`endif
            .miso    (miso[g])
        );
    end

    function automatic logic bitof(input logic [DW-1:0] w, input int k, input int msb);
        return msb != 0 ? w[DW-1-k] : w[k];
    endfunction

    // Handshake is seen at the negedge before the accepting posedge, hence the extra cycle.
    function automatic int exp_lat(input int i);
        return (2 + 2 * DW) * CD_A[i] + 1;
    endfunction

    // Slave: reacts to observed sclk transitions, presents miso on shift edges and captures mosi on sample edges.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                miso[i] = 1'b0;
            end else begin
                if (tx_valid[i] && tx_ready[i]) begin
                    nacc[i]++;
                    acc_cyc[i] = cyc;
                end
                if (cs_n[i] && sclk[i] !== 1'(CPOL_A[i])) idle_bad[i]++;
                if (cs_n[i]) hi_run[i]++;
                if (!prev_cs[i] && cs_n[i]) rise_cyc[i] = cyc;
                if (prev_cs[i] && !cs_n[i]) begin
                    fall_cyc[i] = cyc;
                    gap[i] = hi_run[i];
                    nedge[i] = 0;
                    nsamp[i] = 0;
                    got[i] = '0;
                    bidx[i] = CPHA_A[i] != 0 ? 0 : 1;
                    if (CPHA_A[i] == 0) miso[i] = bitof(slv_word[i], 0, MSB_A[i]);
                end else if (!cs_n[i] && sclk[i] !== prev_sclk[i]) begin
                    nedge[i]++;
                    if ((prev_sclk[i] == 1'(CPOL_A[i])) == (CPHA_A[i] == 0)) begin
                        if (nsamp[i] < DW) got[i][MSB_A[i] != 0 ? DW - 1 - nsamp[i] : nsamp[i]] = mosi[i];
                        nsamp[i]++;
                    end else begin
                        if (bidx[i] < DW) miso[i] = bitof(slv_word[i], bidx[i], MSB_A[i]);
                        bidx[i]++;
                    end
                end
                if (!cs_n[i]) hi_run[i] = 0;
                if (rx_valid[i]) begin
                    nrx[i]++;
                    rx_cyc[i] = cyc;
                    last_lat[i] = cyc - acc_cyc[i];
                    last_rx[i] = rx_data[i];
                    last_got[i] = got[i];
                    last_nedge[i] = nedge[i];
                end
            end
            prev_sclk[i] = sclk[i];
            prev_cs[i] = rst ? 1'b1 : cs_n[i];
        end
    end

    task automatic run_frame(input int i, input logic [DW-1:0] tx, input logic [DW-1:0] sw, output bit ok);
        int a0, n0;
        @(posedge clk);
        #1;
        a0 = nacc[i];
        n0 = nrx[i];
        slv_word[i] = sw;
        tx_data[i] = tx;
        tx_valid[i] = 1'b1;
        for (int k = 0; k < 100 && nacc[i] == a0; k++) @(posedge clk);
        #1 tx_valid[i] = 1'b0;
        for (int k = 0; k < 400 && nrx[i] == n0; k++) @(posedge clk);
        ok = nacc[i] == a0 + 1 && nrx[i] == n0 + 1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            checks++; if (sclk[i] !== 1'(CPOL_A[i])) begin errors++; $display("FAIL reset_sclk[%0d]: got %b want %b", i, sclk[i], 1'(CPOL_A[i])); end
            checks++; if (cs_n[i] !== 1'b1) begin errors++; $display("FAIL reset_cs_n[%0d]: got %b want 1", i, cs_n[i]); end
            checks++; if (mosi[i] !== 1'b0) begin errors++; $display("FAIL reset_mosi[%0d]: got %b want 0", i, mosi[i]); end
            checks++; if (tx_ready[i] !== 1'b1) begin errors++; $display("FAIL reset_tx_ready[%0d]: got %b want 1", i, tx_ready[i]); end
            checks++; if (rx_valid[i] !== 1'b0) begin errors++; $display("FAIL reset_rx_valid[%0d]: got %b want 0", i, rx_valid[i]); end
            checks++; if (rx_data[i] !== '0) begin errors++; $display("FAIL reset_rx_data[%0d]: got %h want 000", i, rx_data[i]); end
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_mode0;
        bit ok;
        run_frame(0, 12'hAAA, 12'h5C3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mode0_done: frame timed out"); end
        checks++; if (last_rx[0] !== 12'h5C3) begin errors++; $display("FAIL mode0_rx: got %h want 5c3", last_rx[0]); end
        checks++; if (last_got[0] !== 12'hAAA) begin errors++; $display("FAIL mode0_mosi: got %h want aaa", last_got[0]); end
        checks++; if (last_lat[0] !== exp_lat(0)) begin errors++; $display("FAIL mode0_latency: got %0d want %0d", last_lat[0], exp_lat(0)); end
        checks++; if (fall_cyc[0] !== acc_cyc[0] + 1) begin errors++; $display("FAIL mode0_cs_fall: got %0d want %0d", fall_cyc[0], acc_cyc[0] + 1); end
        checks++; if (rise_cyc[0] !== rx_cyc[0]) begin errors++; $display("FAIL mode0_cs_rise: got %0d want %0d", rise_cyc[0], rx_cyc[0]); end
        checks++; if (last_nedge[0] !== 2 * DW) begin errors++; $display("FAIL mode0_edges: got %0d want %0d", last_nedge[0], 2 * DW); end
    endtask

    task automatic test_mode3;
        bit ok;
        checks++; if (sclk[1] !== 1'b1) begin errors++; $display("FAIL mode3_idle: got %b want 1", sclk[1]); end
        run_frame(1, 12'h0F1, 12'hF0E, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mode3_done: frame timed out"); end
        checks++; if (last_rx[1] !== 12'hF0E) begin errors++; $display("FAIL mode3_rx: got %h want f0e", last_rx[1]); end
        checks++; if (last_got[1] !== 12'h0F1) begin errors++; $display("FAIL mode3_mosi: got %h want 0f1", last_got[1]); end
        checks++; if (last_nedge[1] !== 24) begin errors++; $display("FAIL mode3_edges: got %0d want 24", last_nedge[1]); end
        checks++; if (last_lat[1] !== exp_lat(1)) begin errors++; $display("FAIL mode3_latency: got %0d want %0d", last_lat[1], exp_lat(1)); end
    endtask

    task automatic test_lsb_zero;
        bit ok;
        run_frame(2, 12'h000, 12'h001, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lsb_done: frame timed out"); end
        checks++; if (last_rx[2] !== 12'h001) begin errors++; $display("FAIL lsb_rx: got %h want 001", last_rx[2]); end
        checks++; if (last_got[2] !== 12'h000) begin errors++; $display("FAIL lsb_mosi: got %h want 000", last_got[2]); end
        checks++; if (last_lat[2] !== exp_lat(2)) begin errors++; $display("FAIL lsb_latency: got %0d want %0d", last_lat[2], exp_lat(2)); end
    endtask

    task automatic test_random;
        bit ok;
        int i;
        logic [DW-1:0] tx, sw;
        for (int n = 0; n < 9; n++) begin
            i = int'($urandom_range(0, 2));
            tx = DW'($urandom);
            sw = DW'($urandom);
            run_frame(i, tx, sw, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_done[%0d]: frame timed out", i); end
            checks++; if (last_rx[i] !== sw) begin errors++; $display("FAIL rand_rx[%0d]: got %h want %h", i, last_rx[i], sw); end
            checks++; if (last_got[i] !== tx) begin errors++; $display("FAIL rand_mosi[%0d]: got %h want %h", i, last_got[i], tx); end
            checks++; if (last_lat[i] !== exp_lat(i)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, last_lat[i], exp_lat(i)); end
        end
    endtask

    task automatic test_back_to_back;
        int a0, n0, rx1_cyc;
        logic [DW-1:0] rx1, got1;
        @(posedge clk);
        #1;
        a0 = nacc[0];
        n0 = nrx[0];
        slv_word[0] = 12'h3C5;
        tx_data[0] = 12'h123;
        tx_valid[0] = 1'b1;
        for (int k = 0; k < 100 && nacc[0] == a0; k++) @(posedge clk);
        #1 tx_data[0] = 12'h456;
        for (int k = 0; k < 400 && nrx[0] == n0; k++) @(posedge clk);
        rx1 = last_rx[0];
        got1 = last_got[0];
        rx1_cyc = rx_cyc[0];
        for (int k = 0; k < 100 && nacc[0] < a0 + 2; k++) @(posedge clk);
        #1 tx_valid[0] = 1'b0;
        checks++; if (acc_cyc[0] !== rx1_cyc) begin errors++; $display("FAIL b2b_accept: got cycle %0d want %0d", acc_cyc[0], rx1_cyc); end
        for (int k = 0; k < 400 && nrx[0] < n0 + 2; k++) @(posedge clk);
        checks++; if (nrx[0] !== n0 + 2) begin errors++; $display("FAIL b2b_done: got %0d frames want 2", nrx[0] - n0); end
        checks++; if (rx1 !== 12'h3C5) begin errors++; $display("FAIL b2b_rx1: got %h want 3c5", rx1); end
        checks++; if (got1 !== 12'h123) begin errors++; $display("FAIL b2b_mosi1: got %h want 123", got1); end
        checks++; if (last_got[0] !== 12'h456) begin errors++; $display("FAIL b2b_mosi2: got %h want 456", last_got[0]); end
        checks++; if (gap[0] !== 1) begin errors++; $display("FAIL b2b_cs_gap: got %0d want 1", gap[0]); end
    endtask

    task automatic test_reset_abort;
        int a0, n0;
        bit ok;
        @(posedge clk);
        #1;
        a0 = nacc[0];
        slv_word[0] = 12'h000;
        tx_data[0] = 12'hFFF;
        tx_valid[0] = 1'b1;
        for (int k = 0; k < 100 && nacc[0] == a0; k++) @(posedge clk);
        #1 tx_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (cs_n[0] !== 1'b0 || mosi[0] !== 1'b1) begin errors++; $display("FAIL abort_pre: got cs_n=%b mosi=%b want 0/1", cs_n[0], mosi[0]); end
        n0 = nrx[0];
        rst = 1'b1;
        #1;
        checks++; if (cs_n[0] !== 1'b1) begin errors++; $display("FAIL abort_cs_n: got %b want 1", cs_n[0]); end
        checks++; if (sclk[0] !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b want 0", sclk[0]); end
        checks++; if (mosi[0] !== 1'b0) begin errors++; $display("FAIL abort_mosi: got %b want 0", mosi[0]); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (80) @(posedge clk);
        checks++; if (nrx[0] !== n0) begin errors++; $display("FAIL abort_no_rx_valid: got %0d pulses want 0", nrx[0] - n0); end
        run_frame(0, 12'h6E1, 12'h2B4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_recover_done: frame timed out"); end
        checks++; if (last_rx[0] !== 12'h2B4) begin errors++; $display("FAIL abort_recover_rx: got %h want 2b4", last_rx[0]); end
    endtask

`ifdef SPI_MASTER_LOOPBACK_EN
    task automatic test_loopback;
        bit ok;
        loopback[0] = 1'b1;
        run_frame(0, 12'h9B7, 12'h248, ok);
        loopback[0] = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL loopback_done: frame timed out"); end
        checks++; if (last_rx[0] !== 12'h9B7) begin errors++; $display("FAIL loopback_rx: got %h want 9b7", last_rx[0]); end
        checks++; if (last_got[0] !== 12'h9B7) begin errors++; $display("FAIL loopback_mosi: got %h want 9b7", last_got[0]); end
    endtask
`endif

    task automatic test_idle_level;
        for (int i = 0; i < 3; i++) begin
            checks++; if (idle_bad[i] !== 0) begin errors++; $display("FAIL idle_sclk[%0d]: %0d cycles off idle level with cs_n high", i, idle_bad[i]); end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_mode0();
        test_mode3();
        test_lsb_zero();
        test_random();
        test_back_to_back();
        test_reset_abort();
`ifdef SPI_MASTER_LOOPBACK_EN
        test_loopback();
`endif
        test_idle_level();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parameterised full-duplex SPI master that serialises a DATA_W-bit word onto MOSI and captures DATA_W bits from MISO in the same frame. It supports all four CPOL/CPHA modes, a programmable SCLK divider and a valid/ready host handshake. It sits between the host-side datapath and an external SPI slave and supersedes the fixed 12-bit, transmit-only master. All flops run on clk; SCLK is a registered output, never used as a clock.

## Interface
- DATA_W, 12: frame length in bits, 2..32
- CLK_DIV, 2: SCLK half-period in clk cycles, ≥1
- CPOL, 0: SCLK idle level
- CPHA, 0: 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing
- MSB_FIRST, 1: bit order for both directions

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tx_data  in  DATA_W  word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  master can accept a word (high only in IDLE)
- rx_data  out  DATA_W  last received word, held until next frame completes
- rx_valid  out  1  one-cycle pulse when rx_data updates
- sclk  out  1  serial clock
- cs_n  out  1  chip select, active low
- mosi  out  1  serial data out
- miso  in  1  serial data in

## Operation
- Reset values: sclk=CPOL, cs_n=1, mosi=0, tx_ready=1, rx_valid=0, rx_data=0; FSM enters IDLE.
- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE: tx_ready=1. When tx_valid && tx_ready, latch tx_data into the shift register, drive cs_n=0 and go to SETUP. A data value of 0 is a legal frame.
- SETUP: lasts CLK_DIV cycles. If CPHA=0, mosi presents the first bit on entry. Then go to XFER.
- XFER: generates exactly 2·DATA_W SCLK edges, one every CLK_DIV cycles.
  - Odd-numbered edges are leading edges; even-numbered edges are trailing edges.
  - Sample edges latch miso into the receive shift register.
  - Shift edges advance mosi to the next bit. The shift edge that would follow the last bit is suppressed.
  - After the final edge, sclk equals CPOL. Go to HOLD.
- HOLD: lasts CLK_DIV cycles with cs_n still 0. On exit, in the same cycle:
  - cs_n=1, mosi=0;
  - rx_data is loaded from the receive shift register;
  - rx_valid=1 for that single cycle;
  - the FSM returns to IDLE.
- tx_valid asserted while not in IDLE is ignored; the upstream block holds the word until it is accepted.
- MSB_FIRST=0 reverses the bit order on both MOSI and MISO; rx_data is always presented in natural order.
- Reset asserted mid-frame aborts immediately: all outputs return to their reset values and no rx_valid is produced.

## Timing
- Acceptance to rx_valid: (2 + 2·DATA_W)·CLK_DIV cycles. For DATA_W=12, CLK_DIV=2 this is 52 cycles.
- Earliest next acceptance: the cycle after rx_valid. cs_n is therefore high for at least 1 clk cycle between frames.
- miso is sampled at the clk edge on which sclk makes its sample transition. The slave must drive miso at least one clk cycle before that edge.
- SCLK period is 2·CLK_DIV clk cycles. With CLK_DIV=1, SCLK runs at clk/2.

## Configuration
- SPI_MASTER_LOOPBACK_EN defined:
  - adds input loopback (1 bit);
  - when loopback=1, the receive path samples the internal mosi instead of the miso pin, so rx_data equals the transmitted word;
  - the sclk, cs_n and mosi pins still toggle normally.
- SPI_MASTER_LOOPBACK_EN undefined: no loopback port, and miso is the only receive source.

## Structure
- Shared package spi_pkg contains:
  - the FSM state enum (IDLE, SETUP, XFER, HOLD);
  - mode constants SPI_MODE0..SPI_MODE3 as {CPOL,CPHA} pairs;
  - a helper function returning the frame length in clk cycles for given DATA_W and CLK_DIV.
- One sub-module, spi_sclk_gen, contains:
  - the CLK_DIV counter and sclk toggle register;
  - one-cycle leading-edge and trailing-edge strobes for the FSM;
  - an enable input from the FSM.

## Test plan
- Mode 0, DATA_W=12, CLK_DIV=2, tx_data=0xAAA, slave model returns 0x5C3 → MOSI carries 101010101010 MSB-first, rx_data=0x5C3, rx_valid pulses 52 cycles after acceptance, cs_n low for the whole frame.
- Mode 3 (CPOL=1, CPHA=1), tx_data=0x0F1, slave returns 0xF0E → sclk idles high, rx_data=0xF0E, exactly 24 sclk edges.
- tx_data=0x000 with MSB_FIRST=0, slave returns 0x001 → frame still runs, first MISO bit lands in rx_data[0], rx_data=0x001.
- Back-to-back: tx_valid held high with two words 0x123 then 0x456 → second word accepted the cycle after the first rx_valid, cs_n high for exactly 1 cycle between frames.
- rst pulsed 10 cycles into a frame → cs_n=1, sclk=CPOL, mosi=0 immediately, no rx_valid; a new frame after reset completes normally.
- SPI_MASTER_LOOPBACK_EN with loopback=1, tx_data=0x9B7 → rx_data=0x9B7 regardless of miso.
